// File: rtl/key_led_ctrl_pkg.sv
// Shared mode encodings and LED load patterns for the key-to-LED controller.
package key_led_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLOW_L = 3'd1,
        FLOW_R = 3'd2,
        BLINK  = 3'd3,
        ALL_ON = 3'd4
    } mode_e;

    localparam logic [3:0] LED_OFF    = 4'b0000;
    localparam logic [3:0] LED_FLOW_L = 4'b0001;
    localparam logic [3:0] LED_FLOW_R = 4'b1000;
    localparam logic [3:0] LED_BLINK  = 4'b1111;
    localparam logic [3:0] LED_ALL_ON = 4'b1111;

    function automatic logic [3:0] load_pattern(input mode_e m);
        case (m)
            FLOW_L:  load_pattern = LED_FLOW_L;
            FLOW_R:  load_pattern = LED_FLOW_R;
            BLINK:   load_pattern = LED_BLINK;
            ALL_ON:  load_pattern = LED_ALL_ON;
            default: load_pattern = LED_OFF;
        endcase
    endfunction

endpackage

// File: rtl/key_led_ctrl_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level and press pulse.
module key_debounce #(
    parameter int DB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic stable,
    output logic press
);

    localparam int DB_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CNT - 1);

    logic            key_m;
    logic            key_s;
    logic            stable_prev;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_m       <= 1'b1;
            key_s       <= 1'b1;
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
        end else begin
            key_m       <= key_raw;
            key_s       <= key_m;
            stable_prev <= stable;
            // Any sample agreeing with the accepted level restarts the count.
            if (key_s == stable) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                stable <= key_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable_prev & ~stable;

endmodule

// File: rtl/key_led_ctrl.sv
// Four debounced keys select an LED display mode; animated modes advance on a step timer.
// Build option KEY_LED_TOGGLE_EN: re-pressing the current mode's key returns to IDLE.
module key_led_ctrl
    import key_led_ctrl_pkg::*;
#(
    parameter int DB_CNT   = 1_000_000,
    parameter int STEP_CNT = 10_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key,
    output logic [3:0] led,
    output logic [2:0] mode
);

    localparam int STEP_W = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CNT - 1);

    logic [3:0]        key_lvl;
    logic [3:0]        press_raw;
    logic [3:0]        press_q;
    mode_e             state_q;
    mode_e             state_d;
    mode_e             win_mode;
    logic [3:0]        led_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              step;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DB_CNT(DB_CNT)) u_db (
            .clk     (sys_clk),
            .rst_n   (sys_rst_n),
            .key_raw (key[i]),
            .stable  (key_lvl[i]),
            .press   (press_raw[i])
        );
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            led     <= LED_OFF;
            step_q  <= '0;
            press_q <= '0;
        end else begin
            state_q <= state_d;
            led     <= led_d;
            step_q  <= step_d;
            press_q <= press_raw & ~key_lvl;
        end
    end

    always_comb begin
        win_mode = IDLE;
        state_d  = state_q;
        led_d    = led;
        step_d   = '0;
        step     = (step_q == STEP_MAX);

        // Fixed priority: lowest key index wins, the rest are dropped.
        if (press_q[0])      win_mode = FLOW_L;
        else if (press_q[1]) win_mode = FLOW_R;
        else if (press_q[2]) win_mode = BLINK;
        else if (press_q[3]) win_mode = ALL_ON;

        if (press_q != 4'b0000) begin
`ifdef KEY_LED_TOGGLE_EN
            if (win_mode == state_q) begin
                state_d = IDLE;
                led_d   = LED_OFF;
            end else begin
                state_d = win_mode;
                led_d   = load_pattern(win_mode);
            end
`else
            state_d = win_mode;
            led_d   = load_pattern(win_mode);
`endif
        end else begin
            case (state_q)
                FLOW_L:  if (step) led_d = {led[2:0], led[3]};
                FLOW_R:  if (step) led_d = {led[0], led[3:1]};
                BLINK:   if (step) led_d = ~led;
                default: ;
            endcase
            if (state_q inside {FLOW_L, FLOW_R, BLINK})
                step_d = step ? '0 : step_q + 1'b1;
        end
    end

    assign mode = state_q;

endmodule
